pool_a2_stream: RTL and testbench

Streaming 2x2/stride-2 max-pool stage sitting directly downstream of the first convolution datapath: it consumes the post-ReLU pixel stream (one output pixel per valid cycle, raster order, one feature map per filter) and writes the pooled 14x14 maps into the next layer's per-filter IFM memories. Pooling is done on the fly with a half-row line buffer, so no full-map storage is needed. Input values are post-ReLU (non-negative), so the max uses an unsigned compare, which is correct for both fixed-point and IEEE half-precision encodings.

---
 rtl/pool_a2_stream_if.sv | 26 ++
 rtl/pool_a2_stream.sv | 114 +++++++++++
 tb/tb_pool_a2_stream.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pool_a2_stream_if.sv
// Pixel-in / pooled-pixel-out bundle for pool_a2_stream.
// The master drives the pixel stream; the slave (the pooling stage) drives the write port.
interface pool_a2_stream_if #(
  parameter int DATA_WIDTH            = 16,
  parameter int NUMBER_OF_FILTERS     = 6,
  parameter int ADDRESS_SIZE_NEXT_IFM = 8
);
  logic                             start;
  logic [DATA_WIDTH-1:0]            data_in;
  logic                             data_valid;
  logic [DATA_WIDTH-1:0]            ofm_data;
  logic [ADDRESS_SIZE_NEXT_IFM-1:0] ofm_address;
  logic [NUMBER_OF_FILTERS-1:0]     ofm_enable_write;
  logic                             busy;
  logic                             done;

  modport master (
    output start, data_in, data_valid,
    input  ofm_data, ofm_address, ofm_enable_write, busy, done
  );

  modport slave (
    input  start, data_in, data_valid,
    output ofm_data, ofm_address, ofm_enable_write, busy, done
  );
endinterface

// File: rtl/pool_a2_stream.sv
// Streaming 2x2/stride-2 max-pool over raster-ordered post-ReLU maps, using a half-row
// line buffer; writes pooled pixels into per-filter memories through a one-hot strobe.
module pool_a2_stream #(
  parameter int DATA_WIDTH            = 16,
  parameter int IFM_SIZE              = 28,
  parameter int NUMBER_OF_FILTERS     = 6,
  parameter int IFM_SIZE_NEXT         = IFM_SIZE / 2,
  parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT)
) (
  input  logic               clk,
  input  logic               reset,
  pool_a2_stream_if.slave    bus
);
  localparam int CW = (IFM_SIZE > 1) ? $clog2(IFM_SIZE) : 1;
  localparam int HW = (IFM_SIZE_NEXT > 1) ? $clog2(IFM_SIZE_NEXT) : 1;
  localparam int FW = (NUMBER_OF_FILTERS > 1) ? $clog2(NUMBER_OF_FILTERS) : 1;
  localparam int AW = ADDRESS_SIZE_NEXT_IFM;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                       state_q;
  logic [CW-1:0]                col_q, row_q;
  logic [FW-1:0]                filter_q;
  logic [DATA_WIDTH-1:0]        h_q;
  logic [DATA_WIDTH-1:0]        line_buf_q [IFM_SIZE_NEXT];
  logic [DATA_WIDTH-1:0]        ofm_data_q;
  logic [AW-1:0]                ofm_address_q;
  logic [NUMBER_OF_FILTERS-1:0] ofm_we_q;
  logic                         busy_q, done_q;

  logic                         accept, col_last, row_last, filter_last, last_pixel;
  logic [HW-1:0]                col_half;
  logic [DATA_WIDTH-1:0]        hmax_d, lb_rd, result_d;
  logic [AW-1:0]                addr_d;
  logic [NUMBER_OF_FILTERS-1:0] onehot_d;

  always_comb begin
    accept      = (state_q == RUN) && bus.data_valid;
    col_last    = (col_q == CW'(IFM_SIZE - 1));
    row_last    = (row_q == CW'(IFM_SIZE - 1));
    filter_last = (filter_q == FW'(NUMBER_OF_FILTERS - 1));
    last_pixel  = col_last && row_last && filter_last;
    col_half    = HW'(col_q >> 1);
    // Unsigned compares are valid because inputs are non-negative; ties keep the older value.
    hmax_d      = (bus.data_in > h_q) ? bus.data_in : h_q;
    lb_rd       = line_buf_q[col_half];
    result_d    = (hmax_d > lb_rd) ? hmax_d : lb_rd;
    addr_d      = AW'(row_q >> 1) * AW'(IFM_SIZE_NEXT) + AW'(col_q >> 1);
    onehot_d    = '0;
    for (int unsigned f = 0; f < NUMBER_OF_FILTERS; f++) begin
      onehot_d[f] = (filter_q == FW'(f));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      col_q         <= '0;
      row_q         <= '0;
      filter_q      <= '0;
      h_q           <= '0;
      ofm_data_q    <= '0;
      ofm_address_q <= '0;
      ofm_we_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      ofm_we_q <= '0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q  <= RUN;
            col_q    <= '0;
            row_q    <= '0;
            filter_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            col_q <= col_last ? '0 : col_q + 1'b1;
            if (col_last) row_q <= row_last ? '0 : row_q + 1'b1;
            if (col_last && row_last) filter_q <= filter_last ? '0 : filter_q + 1'b1;
            if (!col_q[0]) h_q <= bus.data_in;
            if (col_q[0] && row_q[0]) begin
              ofm_data_q    <= result_d;
              ofm_address_q <= addr_d;
              ofm_we_q      <= onehot_d;
            end
            if (last_pixel) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Contents are don't-care after reset: every entry is written on an even row before use.
  always_ff @(posedge clk) begin
    if (accept && col_q[0] && !row_q[0]) line_buf_q[col_half] <= hmax_d;
  end

  assign bus.ofm_data         = ofm_data_q;
  assign bus.ofm_address      = ofm_address_q;
  assign bus.ofm_enable_write = ofm_we_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
endmodule

// File: tb/tb_pool_a2_stream.sv
// Scoreboard bench for pool_a2_stream: a max-of-window reference model queues expected
// writes, and a negedge monitor pops and compares each write the DUT performs.
module tb_pool_a2_stream;
  localparam int DW  = 16;
  localparam int IFM = 28;
  localparam int NF  = 6;
  localparam int NXT = 14;
  localparam int AW  = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pool_a2_stream_if #(.DATA_WIDTH(DW), .NUMBER_OF_FILTERS(NF), .ADDRESS_SIZE_NEXT_IFM(AW)) bus ();
  pool_a2_stream_if #(.DATA_WIDTH(DW), .NUMBER_OF_FILTERS(1), .ADDRESS_SIZE_NEXT_IFM(2)) bus4 ();

  pool_a2_stream #(.DATA_WIDTH(DW), .IFM_SIZE(IFM), .NUMBER_OF_FILTERS(NF)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  pool_a2_stream #(.DATA_WIDTH(DW), .IFM_SIZE(4), .NUMBER_OF_FILTERS(1)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4));

  typedef struct {int f; int addr; int data; bit last;} exp_t;
  exp_t q[$];
  logic [DW-1:0] pix [NF][IFM][IFM];

  int n_cmp = 0;
  int n_bad = 0;
  int writes = 0;
  int w4 = 0;
  int exp4_a[4] = '{0, 1, 2, 3};
  int exp4_d[4] = '{5, 7, 13, 15};

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.ofm_enable_write != '0 || bus.done) begin
      writes++;
      if (q.size() == 0) begin
        check("unexpected_write", {bus.done, bus.ofm_enable_write}, 0);
      end else begin
        e = q.pop_front();
        check("we", bus.ofm_enable_write, 64'(1) << e.f);
        check("addr", bus.ofm_address, e.addr);
        check("data", bus.ofm_data, e.data);
        check("done_with_write", bus.done, e.last);
      end
    end
  end

  always @(negedge clk) begin
    if (bus4.ofm_enable_write != '0 || bus4.done) begin
      if (w4 < 4) begin
        check("s1_addr", bus4.ofm_address, exp4_a[w4]);
        check("s1_data", bus4.ofm_data, exp4_d[w4]);
        check("s1_done", bus4.done, (w4 == 3) ? 1 : 0);
      end else begin
        check("s1_extra_write", w4, 3);
      end
      w4++;
    end
  end

  task automatic fill(input int mode);
    for (int f = 0; f < NF; f++)
      for (int r = 0; r < IFM; r++)
        for (int c = 0; c < IFM; c++) begin
          case (mode)
            0: pix[f][r][c] = DW'(f * 1000 + r * IFM + c);
            1: pix[f][r][c] = (((r % 2) * 2 + (c % 2)) == ((r / 2 + c / 2 + f) % 4))
                              ? 16'h7C00 : 16'h0001;
            2: pix[f][r][c] = DW'(16'h1234 + f);
            default: pix[f][r][c] = DW'($urandom_range(16'h7BFF));
          endcase
        end
  endtask

  task automatic push_expected();
    exp_t e;
    int m;
    for (int f = 0; f < NF; f++)
      for (int pr = 0; pr < NXT; pr++)
        for (int pc = 0; pc < NXT; pc++) begin
          m = 0;
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
              if (int'(pix[f][2*pr+dr][2*pc+dc]) > m) m = int'(pix[f][2*pr+dr][2*pc+dc]);
          e.f = f;
          e.addr = pr * NXT + pc;
          e.data = m;
          e.last = (f == NF - 1) && (pr == NXT - 1) && (pc == NXT - 1);
          q.push_back(e);
        end
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_data"}, bus.ofm_data, 0);
    check({nm, "_addr"}, bus.ofm_address, 0);
    check({nm, "_we"}, bus.ofm_enable_write, 0);
    check({nm, "_busy"}, bus.busy, 0);
    check({nm, "_done"}, bus.done, 0);
  endtask

  task automatic run(input int gap_pct, input int stop_after, input bit poke_start);
    int n = 0;
    @(posedge clk) #1 bus.start = 1'b1;
    @(posedge clk) #1 bus.start = 1'b0;
    check("busy_rise", bus.busy, 1);
    for (int f = 0; f < NF; f++)
      for (int r = 0; r < IFM; r++)
        for (int c = 0; c < IFM; c++) begin
          if (n == stop_after) return;
          while (int'($urandom_range(99)) < gap_pct) begin
            bus.data_valid = 1'b0;
            bus.data_in    = DW'($urandom);
            @(posedge clk) #1;
          end
          bus.data_valid = 1'b1;
          bus.data_in    = pix[f][r][c];
          bus.start      = poke_start && ($urandom_range(15) == 0);
          @(posedge clk) #1;
          n++;
        end
    bus.data_valid = 1'b0;
    bus.start      = 1'b0;
    check("done_pulse", bus.done, 1);
    check("busy_fall", bus.busy, 0);
    @(posedge clk) #1;
    check("done_once", bus.done, 0);
    check("queue_drained", q.size(), 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL timeout: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int wbefore;
    bus.start = 1'b0; bus.data_valid = 1'b0; bus.data_in = '0;
    bus4.start = 1'b0; bus4.data_valid = 1'b0; bus4.data_in = '0;
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    reset = 1'b1;

    // 4x4 single map, pixels 0..15.
    @(posedge clk) #1 bus4.start = 1'b1;
    @(posedge clk) #1 bus4.start = 1'b0;
    check("s1_busy_rise", bus4.busy, 1);
    for (int i = 0; i < 16; i++) begin
      bus4.data_valid = 1'b1;
      bus4.data_in    = DW'(i);
      @(posedge clk) #1;
    end
    bus4.data_valid = 1'b0;
    check("s1_done_pulse", bus4.done, 1);
    check("s1_busy_fall", bus4.busy, 0);
    @(posedge clk) #1;
    check("s1_write_count", w4, 4);
    check("s1_busy_after", bus4.busy, 0);

    // data_valid while idle must be ignored.
    repeat (20) begin
      bus.data_valid = 1'b1;
      bus.data_in    = DW'($urandom);
      @(posedge clk) #1;
    end
    bus.data_valid = 1'b0;
    check("idle_busy", bus.busy, 0);

    fill(0); push_expected(); run(0, 1 << 30, 1'b0);
    fill(0); push_expected(); run(50, 1 << 30, 1'b1);
    fill(1); push_expected(); run(0, 1 << 30, 1'b0);
    fill(2); push_expected(); run(30, 1 << 30, 1'b1);
    fill(3); push_expected(); run(50, 1 << 30, 1'b1);

    // Abort mid-run with reset after 100 pixels.
    fill(0); push_expected();
    wbefore = writes;
    run(0, 100, 1'b0);
    bus.data_valid = 1'b0;
    @(posedge clk) #1;
    @(posedge clk) #1;
    check("pre_reset_writes", writes - wbefore, 22);
    reset = 1'b0;
    #1 check_zero("abort");
    q.delete();
    repeat (3) @(posedge clk);
    #1 check_zero("abort_hold");
    reset = 1'b1;
    repeat (5) begin
      bus.data_valid = 1'b1;
      bus.data_in    = DW'($urandom);
      @(posedge clk) #1;
    end
    bus.data_valid = 1'b0;
    check("post_reset_idle_busy", bus.busy, 0);
    fill(0); push_expected(); run(0, 1 << 30, 1'b0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
